// File: rtl/mode_pkg.sv
// Shared constants and types for the mode sequencer.
// Mode encodings, default sizes and the index-width helper.
package mode_pkg;

  typedef enum logic [1:0] {
    MODE_TIMER     = 2'd0,
    MODE_STOPWATCH = 2'd1,
    MODE_ALARM     = 2'd2
  } mode_e;

  localparam int NUM_MODES_DEF = 3;
  localparam int DEB_CNT_DEF   = 20;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Control/status bundle between a mode sequencer and its user.
// master drives the controls, slave is the sequencer.
interface mode_sequencer_if
  import mode_pkg::*;
#(
  parameter int NUM_MODES = NUM_MODES_DEF,
  parameter int IDX_W     = idx_w(NUM_MODES)
);

  logic                 key_mode;
  logic                 sw_load;
  logic [IDX_W-1:0]     sw_sel;
  logic                 lock;
  logic [IDX_W-1:0]     mode_idx;
  logic [NUM_MODES-1:0] mode_onehot;
  logic                 mode_chg;

  modport master (
    output key_mode, sw_load, sw_sel, lock,
    input  mode_idx, mode_onehot, mode_chg
  );

  modport slave (
    input  key_mode, sw_load, sw_sel, lock,
    output mode_idx, mode_onehot, mode_chg
  );

endinterface

// File: rtl/key_debounce.sv
// Key synchroniser, debouncer and press (0->1) edge detector.
// Release edges produce no pulse.
module key_debounce
  import mode_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_mode,
  output logic key_press
);

  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CNT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= key_mode;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      // reaching DEB_CNT mismatching samples flips the stable level
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign key_press = r_press;

endmodule

// File: rtl/mode_sequencer.sv
// Mode register with key stepping, direct load and lock.
// Outputs index, one-hot decode and a change pulse, all registered.
module mode_sequencer
  import mode_pkg::*;
#(
  parameter int NUM_MODES = NUM_MODES_DEF,
  parameter int DEB_CNT   = DEB_CNT_DEF,
  parameter int RST_MODE  = int'(MODE_TIMER)
) (
  input logic        clk,
  input logic        rst_n,
  mode_sequencer_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_MODES);
  localparam logic [IDX_W:0]   LIM     = (IDX_W + 1)'(NUM_MODES);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_MODES - 1);
  localparam logic [IDX_W-1:0] RST_IDX = IDX_W'(RST_MODE);
  localparam logic [NUM_MODES-1:0] ONE = NUM_MODES'(1);

  logic                 w_press;
  logic                 w_sel_ok;
  logic [IDX_W-1:0]     w_next;
  logic [IDX_W-1:0]     r_idx;
  logic [NUM_MODES-1:0] r_onehot;
  logic                 r_chg;

  key_debounce #(
    .DEB_CNT (DEB_CNT)
  ) u_deb (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_mode  (bus.key_mode),
    .key_press (w_press)
  );

  assign w_sel_ok = {1'b0, bus.sw_sel} < LIM;

  // an out-of-range load is invisible, so a press may still step
  always_comb begin
    w_next = r_idx;
    if (bus.lock) begin
      w_next = r_idx;
    end else if (bus.sw_load && w_sel_ok) begin
      w_next = bus.sw_sel;
    end else if (w_press) begin
      w_next = (r_idx == LAST) ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx    <= RST_IDX;
      r_onehot <= ONE << RST_IDX;
      r_chg    <= 1'b0;
    end else begin
      r_idx    <= w_next;
      r_onehot <= ONE << w_next;
      r_chg    <= (w_next != r_idx);
    end
  end

  assign bus.mode_idx    = r_idx;
  assign bus.mode_onehot = r_onehot;
  assign bus.mode_chg    = r_chg;

endmodule

// File: tb/tb_mode_sequencer.sv
// Scoreboard bench for mode_sequencer (3 modes, debounce 4).
// Window-based key model feeds expected changes to a monitor.
module tb_mode_sequencer;
  import mode_pkg::*;

  localparam int NM = 3;
  localparam int DC = 4;
  localparam int RM = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mode_sequencer_if #(.NUM_MODES(NM)) bus ();

  mode_sequencer #(
    .NUM_MODES (NM),
    .DEB_CNT   (DC),
    .RST_MODE  (RM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int exp_q[$];
  int m_idx = RM;
  bit m_stable = 1'b0;
  int pend = 0;
  bit khist[$];

  // reference: a press is D consecutive synchronised samples
  // differing from the stable level; it acts two edges later
  always @(posedge clk) begin : model
    int old;
    bit pr;
    bit tog;
    if (!rst_n) begin
      khist.delete();
      m_stable = 1'b0;
      pend = 0;
      m_idx = RM;
    end else begin
      pr = (pend == 1);
      if (pend > 0) pend--;
      khist.push_back(bus.key_mode);
      if (khist.size() > 64) void'(khist.pop_front());
      tog = (khist.size() >= DC + 2);
      if (tog)
        for (int j = 2; j <= DC + 1; j++)
          if (khist[khist.size() - 1 - j] == m_stable) tog = 1'b0;
      if (tog) begin
        m_stable = !m_stable;
        if (m_stable) pend = 2;
      end
      old = m_idx;
      if (bus.lock) begin
        m_idx = old;
      end else if (bus.sw_load && int'(bus.sw_sel) < NM) begin
        m_idx = int'(bus.sw_sel);
      end else if (pr) begin
        m_idx = (m_idx + 1) % NM;
      end
      if (m_idx != old) exp_q.push_back(m_idx);
    end
  end

  always @(negedge clk) begin : monitor
    logic [2:0] eo;
    int e;
    eo = 3'(1) << m_idx;
    vecs++;
    if (bus.mode_idx !== 2'(m_idx)) begin
      errs++;
      $display("FAIL idx t=%0t got %0d want %0d", $time, bus.mode_idx, m_idx);
    end
    vecs++;
    if (bus.mode_onehot !== eo) begin
      errs++;
      $display("FAIL onehot t=%0t got %b want %b", $time, bus.mode_onehot, eo);
    end
    if (bus.mode_chg === 1'b1) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL chg_unexpected t=%0t got 1 want 0", $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.mode_idx !== 2'(e)) begin
          errs++;
          $display("FAIL chg_idx t=%0t got %0d want %0d", $time, bus.mode_idx, e);
        end
      end
    end else begin
      vecs++;
      if (bus.mode_chg !== 1'b0 || exp_q.size() != 0) begin
        errs++;
        $display("FAIL chg_missing t=%0t got %b want 1", $time, bus.mode_chg);
        exp_q.delete();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit k, input bit ld, input int sel, input bit lk);
    bus.key_mode = k;
    bus.sw_load  = ld;
    bus.sw_sel   = 2'(sel);
    bus.lock     = lk;
  endtask

  initial begin
    int lat;
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // three presses; first one timed from the first sampling edge
    bus.key_mode = 1'b1;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.mode_idx != 2'd0) begin
        lat = i;
        break;
      end
    end
    vecs++;
    if (lat != DC + 3) begin
      errs++;
      $display("FAIL latency got %0d want %0d", lat, DC + 3);
    end
    tick(2);
    drive(0, 0, 0, 0); tick(12);
    drive(1, 0, 0, 0); tick(10);
    drive(0, 0, 0, 0); tick(12);
    drive(1, 0, 0, 0); tick(10);
    drive(0, 0, 0, 0); tick(12);

    // glitch shorter than the debounce length
    drive(1, 0, 0, 0); tick(3);
    drive(0, 0, 0, 0); tick(10);

    // held valid load, then out-of-range load
    drive(0, 1, 2, 0); tick(5);
    drive(0, 1, 3, 0); tick(3);
    drive(0, 0, 0, 0); tick(3);

    // lock over a press and a load, release with key held
    drive(1, 0, 0, 1); tick(10);
    drive(1, 1, 0, 1); tick(2);
    drive(1, 0, 0, 0); tick(5);
    drive(0, 0, 0, 0); tick(10);

    // press on the same edge as a load of 1
    drive(1, 0, 0, 0); tick(DC + 3);
    drive(1, 1, 1, 0); tick(1);
    drive(1, 0, 0, 0); tick(3);
    drive(0, 0, 0, 0); tick(10);

    // reset with the debounce counter at 2
    drive(1, 0, 0, 0); tick(4);
    rst_n = 1'b0;
    bus.key_mode = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(15);

    // key held through reset release counts once
    drive(1, 0, 0, 0);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    drive(0, 0, 0, 0); tick(10);

    for (int it = 0; it < 1500; it++) begin
      drive(bit'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
      tick(int'($urandom_range(1, 12)));
    end

    drive(0, 0, 0, 0);
    tick(3);
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL queue_drain got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
